fixed_unit_arbiter: RTL and testbench
=====================================

// Module: fixed_unit_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer sharing one multi-cycle fixed-point math unit
//  (reciprocal / inverse-sqrt) among N_REQ requesters.
//  Sits between the math consumers and the single shared unit.
//  Accepts one request, issues it, waits for the result and returns it to the
//  granted requester. One operation is in flight at a time.
// PARAMETERS
//  N_REQ  4  number of requesters (>=1); IDX_W = max(1,$clog2(N_REQ)) is a localparam
// PORTS
//  clk_in          in   1           system clock
//  rst_in          in   1           synchronous, active-high reset
//  req_valid_in    in   N_REQ       per-requester request valid
//  req_op_in       in   N_REQ x 2   fixed_op_t per requester
//  req_operand_in  in   N_REQ x fixed  operand per requester
//  req_ready_out   out  N_REQ       one-hot accept; combinational from state + pick
//  resp_valid_out  out  N_REQ       one-hot response valid, registered
//  resp_data_out   out  fixed       result, shared; meaningful while any resp_valid_out
//  resp_err_out    out  1           set with resp for an OP_RSVD request
//  resp_ready_in   in   N_REQ       per-requester response ready
//  unit_valid_out  out  1           issue to shared unit
//  unit_op_out     out  2           latched op
//  unit_operand_out out fixed       latched operand
//  unit_ready_in   in   1           unit accepts the issue
//  unit_done_in    in   1           one-cycle result strobe
//  unit_result_in  in   fixed       result, valid with unit_done_in
// BEHAVIOUR
//  Reset: state IDLE, rr_ptr=0, all outputs 0, latched op/operand/result/grant = 0.
//  FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE
//   - rr_picker picks the first asserted req_valid_in[i], scanning from rr_ptr upward and wrapping.
//   - req_ready_out[g]=1 that cycle only; latch g, op and operand.
//   - rr_ptr <= (g+1) mod N_REQ.
//   - OP_PASS or OP_RSVD: result <= operand, skip the unit, go to RESP. Err=1 for RSVD.
//   - Otherwise go to ISSUE.
//  ISSUE
//   - unit_valid_out=1 with the latched op/operand, held until unit_ready_in.
//   - unit_ready_in with no done: go to WAIT.
//   - unit_ready_in and unit_done_in in the same cycle: capture the result, go to RESP.
//  WAIT
//   - Hold until unit_done_in. Then resp_data <= unit_result_in, go to RESP. No timeout.
//  RESP
//   - resp_valid_out[g]=1, resp_data_out and resp_err_out stable until resp_ready_in[g].
//   - On handshake: clear resp, go to IDLE.
//   - resp_ready_in of other requesters is ignored.
//  Latency: accept at cycle t; unit_valid_out at t+1; resp_valid_out the cycle after
//   unit_done_in. PASS: resp_valid_out at t+1.
//  Requesters hold valid/op/operand until ready. Changes while not ready have no effect.
//  unit_done_in outside ISSUE/WAIT is ignored.
//  No new grant until RESP completes. Requests arriving meanwhile wait.
//  N_REQ=1: rr_ptr stays 0.
//  Reset mid-operation: the in-flight op is dropped and nothing is returned.
//   The shared unit is reset by the same rst_in.
//  Fairness: a requester that stays asserted is granted within N_REQ grants.
// CONFIGURATION
//  FIXED_ARB_STATS_EN defined:
//   - Adds outputs stat_ops_out[31:0] (count of completed responses) and
//     stat_busy_out[31:0] (cycles with state != IDLE).
//   - Both counters saturate at 32'hFFFF_FFFF and are cleared by rst_in.
//  Undefined: these ports and counters do not exist. All other behaviour is identical.
// STRUCTURE
//  Shared types package:
//   - fixed typedef (32-bit signed Q16.16) and FIXED_W.
//   - fixed_op_t enum: OP_PASS=0, OP_RECIP=1, OP_INV_SQRT=2, OP_RSVD=3.
//   - arb_state_t enum: IDLE, ISSUE, WAIT, RESP.
//  Sub-module rr_picker #(N_REQ):
//   - Inputs: req vector, rr_ptr.
//   - Outputs: any, grant index, one-hot grant. Purely combinational.
// TESTING (bench unit model: fixed latency 5, ready always 1 unless stated)
//  1. Req0 RECIP 32'h0002_0000 -> req_ready_out[0] same cycle; unit_valid_out next cycle;
//     resp_valid_out[0] with 32'h0000_8000 six cycles after issue; err=0.
//  2. Req0..3 all valid INV_SQRT 32'h0004_0000 continuously -> grants 0,1,2,3,0;
//     each response 32'h0000_8000.
//  3. Req2 PASS 32'hFFFF_0000 -> resp_valid_out[2] at t+1 with 32'hFFFF_0000;
//     unit_valid_out never asserted.
//  4. Req1 OP_RSVD 32'h1234_5678 -> response data 32'h1234_5678, err=1, no issue.
//  5. unit_ready_in low for 3 cycles, then done coincident with ready; resp_ready_in[0]
//     low for 4 cycles -> unit_valid_out and operand held; resp held stable;
//     no new grant until the handshake.
//  6. rst_in pulsed in WAIT, then a late unit_done_in -> all outputs 0 and rr_ptr=0 the
//     cycle after reset; late done ignored; stats (if FIXED_ARB_STATS_EN) = 0.

Source files
------------

// File: rtl/fixed_unit_arbiter_pkg.sv
// Shared types for the fixed-point math unit arbiter: Q16.16 data type, op codes, FSM states.
package fixed_unit_arbiter_pkg;

  localparam int FIXED_W = 32;

  typedef logic signed [FIXED_W-1:0] fixed;

  typedef enum logic [1:0] {
    OP_PASS     = 2'd0,
    OP_RECIP    = 2'd1,
    OP_INV_SQRT = 2'd2,
    OP_RSVD     = 2'd3
  } fixed_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // PASS and RSVD are answered locally with the operand; only real math goes to the unit.
  function automatic logic op_skips_unit(input fixed_op_t op);
    return (op == OP_PASS) || (op == OP_RSVD);
  endfunction

endpackage

// File: rtl/fixed_unit_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector, first asserted request at or above rr_ptr, wrapping.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             any,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N_REQ-1:0] grant_oh
);

  // Downward scans leave the lowest hit; the second pass overrides with the lowest hit >= rr_ptr.
  always_comb begin
    any       = |req;
    grant_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) grant_idx = IDX_W'(i);
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(rr_ptr))) grant_idx = IDX_W'(i);
    end
    grant_oh = any ? (N_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/fixed_unit_arbiter.sv
// fixed_unit_arbiter: round-robin sequencer sharing one multi-cycle fixed-point math unit.
// Define FIXED_ARB_STATS_EN to add the stat_ops_out / stat_busy_out counters.
//
// state | meaning
// IDLE  | no operation held; picker drives req_ready_out
// ISSUE | unit_valid_out high with latched op/operand until unit_ready_in
// WAIT  | issued; waiting for unit_done_in
// RESP  | resp_valid_out[grant] held until that requester's resp_ready_in
module fixed_unit_arbiter
  import fixed_unit_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic      [N_REQ-1:0] req_valid_in,
  input  fixed_op_t [N_REQ-1:0] req_op_in,
  input  fixed      [N_REQ-1:0] req_operand_in,
  output logic      [N_REQ-1:0] req_ready_out,
  output logic      [N_REQ-1:0] resp_valid_out,
  output fixed                  resp_data_out,
  output logic                  resp_err_out,
  input  logic      [N_REQ-1:0] resp_ready_in,
  output logic                  unit_valid_out,
  output fixed_op_t             unit_op_out,
  output fixed                  unit_operand_out,
  input  logic                  unit_ready_in,
  input  logic                  unit_done_in,
  input  fixed                  unit_result_in
`ifdef FIXED_ARB_STATS_EN
  ,
  output logic [31:0]           stat_ops_out,
  output logic [31:0]           stat_busy_out
`endif
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant_idx_q;
  fixed_op_t        op_q;
  fixed             operand_q;
  fixed             result_q;
  logic             err_q;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_oh;
  fixed_op_t        pick_op;
  fixed             pick_operand;
  logic [N_REQ-1:0] grant_q_oh;
  logic             resp_hs;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req       (req_valid_in),
    .rr_ptr    (rr_ptr),
    .any       (pick_any),
    .grant_idx (pick_idx),
    .grant_oh  (pick_oh)
  );

  assign pick_op          = req_op_in[pick_idx];
  assign pick_operand     = req_operand_in[pick_idx];
  assign grant_q_oh       = N_REQ'(1) << grant_idx_q;
  assign resp_hs          = (state == RESP) && resp_ready_in[grant_idx_q];

  assign req_ready_out    = (state == IDLE) ? pick_oh : '0;
  assign resp_data_out    = result_q;
  assign resp_err_out     = err_q;
  assign unit_op_out      = op_q;
  assign unit_operand_out = operand_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      grant_idx_q    <= '0;
      op_q           <= OP_PASS;
      operand_q      <= '0;
      result_q       <= '0;
      err_q          <= 1'b0;
      resp_valid_out <= '0;
      unit_valid_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_idx_q <= pick_idx;
            op_q        <= pick_op;
            operand_q   <= pick_operand;
            rr_ptr      <= (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
            if (op_skips_unit(pick_op)) begin
              result_q       <= pick_operand;
              err_q          <= (pick_op == OP_RSVD);
              resp_valid_out <= pick_oh;
              state          <= RESP;
            end else begin
              unit_valid_out <= 1'b1;
              state          <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (unit_ready_in) begin
            unit_valid_out <= 1'b0;
            // A zero-latency unit can finish in the issue cycle itself.
            if (unit_done_in) begin
              result_q       <= unit_result_in;
              err_q          <= 1'b0;
              resp_valid_out <= grant_q_oh;
              state          <= RESP;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (unit_done_in) begin
            result_q       <= unit_result_in;
            err_q          <= 1'b0;
            resp_valid_out <= grant_q_oh;
            state          <= RESP;
          end
        end
        RESP: begin
          if (resp_hs) begin
            resp_valid_out <= '0;
            result_q       <= '0;
            err_q          <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIXED_ARB_STATS_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stat_ops_out  <= '0;
      stat_busy_out <= '0;
    end else begin
      if (resp_hs && (stat_ops_out != 32'hFFFF_FFFF)) stat_ops_out <= stat_ops_out + 32'd1;
      if ((state != IDLE) && (stat_busy_out != 32'hFFFF_FFFF)) stat_busy_out <= stat_busy_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fixed_unit_arbiter.sv
// Directed self-checking bench for fixed_unit_arbiter with a fixed-latency behavioural math unit.
module tb_fixed_unit_arbiter;
  import fixed_unit_arbiter_pkg::*;

  localparam int LAT = 5;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic      [3:0] req_valid_in;
  fixed_op_t [3:0] req_op_in;
  fixed      [3:0] req_operand_in;
  logic      [3:0] req_ready_out;
  logic      [3:0] resp_valid_out;
  fixed            resp_data_out;
  logic            resp_err_out;
  logic      [3:0] resp_ready_in;
  logic            unit_valid_out;
  fixed_op_t       unit_op_out;
  fixed            unit_operand_out;
  logic            unit_ready_in;
  logic            unit_done_in;
  fixed            unit_result_in;
`ifdef FIXED_ARB_STATS_EN
  logic     [31:0] stat_ops_out;
  logic     [31:0] stat_busy_out;
`endif

  int        checks = 0;
  int        errors = 0;
  int        cyc = 0;
  int        done_at = -1;
  logic      model_on;
  fixed_op_t pend_op;
  fixed      pend_x;

  fixed_unit_arbiter #(.N_REQ(4)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .req_valid_in     (req_valid_in),
    .req_op_in        (req_op_in),
    .req_operand_in   (req_operand_in),
    .req_ready_out    (req_ready_out),
    .resp_valid_out   (resp_valid_out),
    .resp_data_out    (resp_data_out),
    .resp_err_out     (resp_err_out),
    .resp_ready_in    (resp_ready_in),
    .unit_valid_out   (unit_valid_out),
    .unit_op_out      (unit_op_out),
    .unit_operand_out (unit_operand_out),
    .unit_ready_in    (unit_ready_in),
    .unit_done_in     (unit_done_in),
    .unit_result_in   (unit_result_in)
`ifdef FIXED_ARB_STATS_EN
    ,
    .stat_ops_out     (stat_ops_out),
    .stat_busy_out    (stat_busy_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  function automatic fixed unit_fn(input fixed_op_t op, input fixed x);
    real xr;
    xr = $itor(x) / 65536.0;
    case (op)
      OP_RECIP:    return fixed'($rtoi(65536.0 / xr));
      OP_INV_SQRT: return fixed'($rtoi(65536.0 / $sqrt(xr)));
      default:     return x;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: the behavioural unit notes an issue handshake, then drives done LAT cycles later.
  task automatic tick();
    logic hs;
    hs = unit_valid_out && unit_ready_in;
    if (model_on && hs) begin
      done_at = cyc + LAT;
      pend_op = unit_op_out;
      pend_x  = unit_operand_out;
    end
    @(posedge clk_in);
    #1;
    cyc++;
    if (model_on) begin
      unit_done_in   = (cyc == done_at);
      unit_result_in = unit_done_in ? unit_fn(pend_op, pend_x) : '0;
    end
  endtask

  task automatic await_grant(input string tag, input logic [3:0] exp_oh);
    int n;
    n = 0;
    while (req_ready_out == 4'b0 && n < 30) begin
      tick();
      n++;
    end
    chk(tag, 32'(req_ready_out), 32'(exp_oh));
  endtask

  task automatic await_resp(input string tag, input logic [3:0] exp_oh, input fixed exp_d,
                            input logic exp_err);
    int n;
    n = 0;
    while (resp_valid_out == 4'b0 && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(resp_valid_out), 32'(exp_oh));
    chk({tag, "_data"}, resp_data_out, exp_d);
    chk({tag, "_err"}, 32'(resp_err_out), 32'(exp_err));
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  initial begin
    int n;
    rst_in         = 1'b1;
    req_valid_in   = '0;
    for (int i = 0; i < 4; i++) begin
      req_op_in[i]      = OP_PASS;
      req_operand_in[i] = '0;
    end
    resp_ready_in  = 4'hF;
    unit_ready_in  = 1'b1;
    unit_done_in   = 1'b0;
    unit_result_in = '0;
    model_on       = 1'b1;
    pend_op        = OP_PASS;
    pend_x         = '0;

    do_reset();
    chk("rst_resp_valid", 32'(resp_valid_out), 32'h0);
    chk("rst_unit_valid", 32'(unit_valid_out), 32'h0);
    chk("rst_resp_data", resp_data_out, 32'h0);
    chk("rst_unit_operand", unit_operand_out, 32'h0);
    chk("rst_req_ready", 32'(req_ready_out), 32'h0);

    // 1: single RECIP of 2.0 from requester 0
    req_valid_in[0] = 1'b1; req_op_in[0] = OP_RECIP; req_operand_in[0] = 32'h0002_0000;
    #1;
    chk("t1_ready", 32'(req_ready_out), 32'h1);
    tick();
    req_valid_in = '0;
    chk("t1_unit_valid", 32'(unit_valid_out), 32'h1);
    chk("t1_unit_op", 32'(unit_op_out), 32'h1);
    chk("t1_unit_operand", unit_operand_out, 32'h0002_0000);
    n = 0;
    while (resp_valid_out == 4'b0 && n < 20) begin
      tick();
      n++;
    end
    chk("t1_latency", 32'(n), 32'd6);
    chk("t1_resp_valid", 32'(resp_valid_out), 32'h1);
    chk("t1_resp_data", resp_data_out, 32'h0000_8000);
    chk("t1_resp_err", 32'(resp_err_out), 32'h0);
    tick();
    chk("t1_resp_clear", 32'(resp_valid_out), 32'h0);

    // 2: all four requesters INV_SQRT of 4.0, continuously valid
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_op_in[i]      = OP_INV_SQRT;
      req_operand_in[i] = 32'h0004_0000;
    end
    req_valid_in = 4'hF;
    #1;
    await_grant("t2_grant0", 4'b0001); tick(); await_resp("t2_resp0", 4'b0001, 32'h0000_8000, 1'b0); tick();
    await_grant("t2_grant1", 4'b0010); tick(); await_resp("t2_resp1", 4'b0010, 32'h0000_8000, 1'b0); tick();
    await_grant("t2_grant2", 4'b0100); tick(); await_resp("t2_resp2", 4'b0100, 32'h0000_8000, 1'b0); tick();
    await_grant("t2_grant3", 4'b1000); tick(); await_resp("t2_resp3", 4'b1000, 32'h0000_8000, 1'b0); tick();
    await_grant("t2_grant4", 4'b0001); tick(); await_resp("t2_resp4", 4'b0001, 32'h0000_8000, 1'b0);
    req_valid_in = '0;
    tick();

    // 3: PASS from requester 2 answers at t+1 without touching the unit
    req_valid_in[2] = 1'b1; req_op_in[2] = OP_PASS; req_operand_in[2] = 32'hFFFF_0000;
    #1;
    chk("t3_ready", 32'(req_ready_out), 32'h4);
    tick();
    req_valid_in = '0;
    chk("t3_resp_valid", 32'(resp_valid_out), 32'h4);
    chk("t3_resp_data", resp_data_out, 32'hFFFF_0000);
    chk("t3_resp_err", 32'(resp_err_out), 32'h0);
    chk("t3_no_issue", 32'(unit_valid_out), 32'h0);
    tick();
    chk("t3_resp_clear", 32'(resp_valid_out), 32'h0);
    chk("t3_no_issue2", 32'(unit_valid_out), 32'h0);

    // 4: reserved op from requester 1 echoes the operand with err set
    req_valid_in[1] = 1'b1; req_op_in[1] = OP_RSVD; req_operand_in[1] = 32'h1234_5678;
    #1;
    chk("t4_ready", 32'(req_ready_out), 32'h2);
    tick();
    req_valid_in = '0;
    chk("t4_resp_valid", 32'(resp_valid_out), 32'h2);
    chk("t4_resp_data", resp_data_out, 32'h1234_5678);
    chk("t4_resp_err", 32'(resp_err_out), 32'h1);
    chk("t4_no_issue", 32'(unit_valid_out), 32'h0);
    tick();

    // 5: unit stalls three cycles, then finishes in the accept cycle; requester stalls the response
    model_on = 1'b0;
    unit_ready_in = 1'b0;
    resp_ready_in = 4'h0;
    req_valid_in[0] = 1'b1; req_op_in[0] = OP_RECIP; req_operand_in[0] = 32'h0002_0000;
    #1;
    chk("t5_ready", 32'(req_ready_out), 32'h1);
    tick();
    req_valid_in = '0;
    req_valid_in[3] = 1'b1; req_op_in[3] = OP_PASS; req_operand_in[3] = 32'h0003_0000;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("t5_hold_valid", 32'(unit_valid_out), 32'h1);
      chk("t5_hold_operand", unit_operand_out, 32'h0002_0000);
      chk("t5_no_grant_issue", 32'(req_ready_out), 32'h0);
      tick();
    end
    unit_ready_in = 1'b1; unit_done_in = 1'b1; unit_result_in = 32'h0000_8000;
    chk("t5_still_valid", 32'(unit_valid_out), 32'h1);
    tick();
    unit_ready_in = 1'b0; unit_done_in = 1'b0; unit_result_in = '0;
    resp_ready_in = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      chk("t5_resp_valid", 32'(resp_valid_out), 32'h1);
      chk("t5_resp_data", resp_data_out, 32'h0000_8000);
      chk("t5_no_grant_resp", 32'(req_ready_out), 32'h0);
      tick();
    end
    resp_ready_in = 4'hF;
    unit_ready_in = 1'b1;
    tick();
    chk("t5_resp_clear", 32'(resp_valid_out), 32'h0);
    chk("t5_next_grant", 32'(req_ready_out), 32'h8);
    tick();
    req_valid_in = '0;
    chk("t5_pass3_data", resp_data_out, 32'h0003_0000);
    tick();
    model_on = 1'b1;

    // 6: reset while waiting on the unit; its late done must not produce a response
    req_valid_in[1] = 1'b1; req_op_in[1] = OP_RECIP; req_operand_in[1] = 32'h0002_0000;
    #1;
    chk("t6_ready", 32'(req_ready_out), 32'h2);
    tick();
    req_valid_in = '0;
    chk("t6_issue", 32'(unit_valid_out), 32'h1);
    tick();
    tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    chk("t6_resp_valid", 32'(resp_valid_out), 32'h0);
    chk("t6_unit_valid", 32'(unit_valid_out), 32'h0);
    chk("t6_unit_op", 32'(unit_op_out), 32'h0);
    chk("t6_unit_operand", unit_operand_out, 32'h0);
    chk("t6_resp_data", resp_data_out, 32'h0);
    chk("t6_resp_err", 32'(resp_err_out), 32'h0);
`ifdef FIXED_ARB_STATS_EN
    chk("t6_stat_ops", stat_ops_out, 32'h0);
    chk("t6_stat_busy", stat_busy_out, 32'h0);
`endif
    tick();
    tick();
    chk("t6_late_done_seen", 32'(unit_done_in), 32'h1);
    tick();
    chk("t6_late_resp", 32'(resp_valid_out), 32'h0);
    chk("t6_late_unit", 32'(unit_valid_out), 32'h0);
    for (int i = 0; i < 4; i++) begin
      req_op_in[i]      = OP_PASS;
      req_operand_in[i] = 32'h0001_0000;
    end
    req_valid_in = 4'hF;
    #1;
    chk("t6_ptr_zero", 32'(req_ready_out), 32'h1);
    tick();
    req_valid_in = '0;
    chk("t6_pass_resp", 32'(resp_valid_out), 32'h1);
    chk("t6_pass_data", resp_data_out, 32'h0001_0000);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
